load_store_unit: RTL and testbench
==================================

# load_store_unit

Executes the `LOAD_STORE` functional-unit instructions of the vector core:
- `LDV` moves one D-element `fixed_point_t` vector from byte-wide DDR into a vector register.
- `SV` moves a vector register out to DDR.

The block sits between the instruction issue stage, which supplies the operation, DDR address and register index, and both the vector register file and the DDR port. It sequences one byte per DDR transaction, with at most one transaction outstanding.

## Interface
Parameters:
- `D`, 16, vector length in elements.
- `DdrAddressWidth`, 16, DDR address width.
- `DdrDataWidth`, 8, DDR data width; equals `FixedPointPrecision`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_i  in  1  clock`
  - `rst_ni  in  1  asynchronous active-low reset`
- Issue side:
  - `start_i  in  1  instruction valid; accepted only when ready_o=1`
  - `ready_o  out  1  unit idle, can accept start_i`
  - `operation_i  in  2  load_store_operation_t: LDV=0, SV=1, others illegal`
  - `ddr_address_i  in  DdrAddressWidth  base byte address`
  - `v_addr_i  in  2  vector register index (v_addr_t)`
  - `done_o  out  1  one-cycle completion pulse`
- Vector register file:
  - `vreg_raddr_o  out  2  read index; combinational read`
  - `vreg_rdata_i  in  D*8  read vector; element i at bits [8i+7:8i]`
  - `vreg_we_o  out  1  write enable, single cycle`
  - `vreg_waddr_o  out  2  write index`
  - `vreg_wdata_o  out  D*8  write vector; same packing as vreg_rdata_i`
- DDR port:
  - `ddr_req_o  out  1  request valid`
  - `ddr_we_o  out  1  1=write, 0=read`
  - `ddr_addr_o  out  DdrAddressWidth  byte address`
  - `ddr_wdata_o  out  DdrDataWidth  write byte`
  - `ddr_gnt_i  in  1  request accepted this cycle`
  - `ddr_rvalid_i  in  1  read data valid`
  - `ddr_rdata_i  in  DdrDataWidth  read byte`

## Operation
- State machine: IDLE, REQ, WAIT_R, WRITEBACK, DONE.
- IDLE:
  - `ready_o=1`.
  - On `start_i=1`, latch operation, base address and register index; clear element counter `i`.
  - SV additionally latches `vreg_rdata_i` into the internal D-byte buffer; `vreg_raddr_o` is driven from `v_addr_i` in IDLE.
  - Next state: REQ for LDV/SV; DONE for an illegal op, which produces no DDR or register traffic.
- REQ:
  - `ddr_req_o=1`, `ddr_addr_o = base + i` (modulo 2^DdrAddressWidth, wraps 0xFFFF→0x0000).
  - `ddr_we_o=1` for SV, 0 for LDV. `ddr_wdata_o` = buffer element `i`.
  - Request signals are held stable until `ddr_gnt_i=1`.
  - On grant:
    - SV: `i++`; if `i==D-1`, go to DONE.
    - LDV: go to WAIT_R.
- WAIT_R:
  - `ddr_req_o=0`.
  - On `ddr_rvalid_i=1`, write `ddr_rdata_i` into buffer element `i`.
  - If `i==D-1`, go to WRITEBACK; else `i++` and go to REQ.
  - `ddr_rvalid_i` outside WAIT_R is ignored.
- WRITEBACK: `vreg_we_o=1` for exactly one cycle, `vreg_waddr_o` = latched index, `vreg_wdata_o` = buffer; next state DONE.
- DONE: `done_o=1` for one cycle; next state IDLE.
- `start_i` while `ready_o=0` is ignored; there is no queueing.
- Counter width is `$clog2(D)`.
- The buffer is preserved between instructions but is never written to the register file except in WRITEBACK.

## Timing
- Reset values of outputs:
  - `ready_o=1`.
  - `done_o`, `ddr_req_o`, `ddr_we_o`, `vreg_we_o` = 0.
  - `ddr_addr_o`, `ddr_wdata_o`, `vreg_waddr_o` = 0; buffer cleared to 0.
- Reset mid-operation:
  - Immediate return to IDLE.
  - No `vreg_we_o` and no `done_o` for the aborted instruction.
  - DDR request drops asynchronously.
- Latency: cycle 0 is the cycle in which `start_i` is accepted.
  - SV with `ddr_gnt_i` tied high: requests in cycles 1..D, `done_o` in cycle D+1, `ready_o` in cycle D+2.
  - LDV with grant tied high and `rvalid` one cycle after grant: 2 cycles per element; WRITEBACK in cycle 2D+1, `done_o` in 2D+2, `ready_o` in 2D+3.
  - Illegal op: `done_o` in cycle 1.
- Each grant stall cycle adds one cycle; each rvalid delay cycle adds one cycle.
- Same-cycle `ddr_gnt_i` and `ddr_rvalid_i` in REQ: rvalid is ignored. The DDR side guarantees rvalid no earlier than one cycle after grant.

## Test plan
- SV: register 2 holds bytes 0x00..0x0F, base 0x0100, grant always high → 16 writes to addresses 0x0100..0x010F with data 0x00..0x0F in order; `done_o` in cycle 17; `vreg_we_o` never asserted.
- LDV: DDR model returns `addr[7:0]` XOR 0xA5 one cycle after grant, base 0x0200, register 1 → exactly one `vreg_we_o` in cycle 33, `waddr=1`, element i = (i XOR 0xA5); `done_o` in cycle 34.
- Grant stalls: random 0–3 cycle grant delays, random 1–4 cycle rvalid delays on LDV → address and data held stable while stalled; results identical to the no-stall case.
- Wrap: SV with base 0xFFF8 → addresses 0xFFF8..0xFFFF then 0x0000..0x0007.
- Busy and illegal:
  - `start_i` pulsed mid-SV → ignored; no extra traffic.
  - `operation_i=2` → `done_o` in cycle 1; no DDR or register activity.
- Reset during LDV after element 7 → all outputs return to reset values; no writeback and no `done_o`; a subsequent LDV completes correctly.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Byte-serial vector load (LDV) / store (SV) between the vector
//            register file and a byte-wide DDR port, one transaction in flight.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int D               = 16,
    parameter int DdrAddressWidth = 16,
    parameter int DdrDataWidth    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    output logic                       ready_o,
    input  logic [1:0]                 operation_i,
    input  logic [DdrAddressWidth-1:0] ddr_address_i,
    input  logic [1:0]                 v_addr_i,
    output logic                       done_o,
    output logic [1:0]                 vreg_raddr_o,
    input  logic [D*DdrDataWidth-1:0]  vreg_rdata_i,
    output logic                       vreg_we_o,
    output logic [1:0]                 vreg_waddr_o,
    output logic [D*DdrDataWidth-1:0]  vreg_wdata_o,
    output logic                       ddr_req_o,
    output logic                       ddr_we_o,
    output logic [DdrAddressWidth-1:0] ddr_addr_o,
    output logic [DdrDataWidth-1:0]    ddr_wdata_o,
    input  logic                       ddr_gnt_i,
    input  logic                       ddr_rvalid_i,
    input  logic [DdrDataWidth-1:0]    ddr_rdata_i
);

    localparam int                 c_cnt_w  = (D > 1) ? $clog2(D) : 1;
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(D - 1);
    localparam logic [1:0]         c_op_ldv = 2'd0;
    localparam logic [1:0]         c_op_sv  = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_R    = 3'd2,
        S_WRITEBACK = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [1:0]                   r_op;
    logic [DdrAddressWidth-1:0]   r_base;
    logic [1:0]                   r_vaddr;
    logic [c_cnt_w-1:0]           r_idx;
    logic [D*DdrDataWidth-1:0]    r_buf;
    logic                         w_is_sv;
    logic                         w_legal;
    logic [DdrDataWidth-1:0]      w_elem;

    assign w_is_sv      = (r_op == c_op_sv);
    assign w_legal      = (operation_i == c_op_ldv) || (operation_i == c_op_sv);
    assign w_elem       = r_buf[int'(r_idx)*DdrDataWidth +: DdrDataWidth];
    assign vreg_waddr_o = r_vaddr;
    assign vreg_wdata_o = r_buf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_base  <= '0;
            r_vaddr <= '0;
            r_idx   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_op    <= operation_i;
                        r_base  <= ddr_address_i;
                        r_vaddr <= v_addr_i;
                        r_idx   <= '0;
                        if (operation_i == c_op_sv) begin
                            r_buf <= vreg_rdata_i;
                        end
                    end
                end
                S_REQ: begin
                    // Loads advance the index only once their byte has returned.
                    if (ddr_gnt_i && w_is_sv) begin
                        r_idx <= r_idx + c_cnt_w'(1);
                    end
                end
                S_WAIT_R: begin
                    if (ddr_rvalid_i) begin
                        r_buf[int'(r_idx)*DdrDataWidth +: DdrDataWidth] <= ddr_rdata_i;
                        if (r_idx != c_last) begin
                            r_idx <= r_idx + c_cnt_w'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready_o      = 1'b0;
        done_o       = 1'b0;
        ddr_req_o    = 1'b0;
        ddr_we_o     = 1'b0;
        ddr_addr_o   = '0;
        ddr_wdata_o  = '0;
        vreg_we_o    = 1'b0;
        vreg_raddr_o = r_vaddr;
        case (r_state)
            S_IDLE: begin
                ready_o      = 1'b1;
                vreg_raddr_o = v_addr_i;
                if (start_i) begin
                    w_state_next = w_legal ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                ddr_req_o   = 1'b1;
                ddr_we_o    = w_is_sv;
                ddr_addr_o  = r_base + DdrAddressWidth'(r_idx);
                ddr_wdata_o = w_elem;
                if (ddr_gnt_i) begin
                    if (!w_is_sv) begin
                        w_state_next = S_WAIT_R;
                    end else if (r_idx == c_last) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_WAIT_R: begin
                if (ddr_rvalid_i) begin
                    w_state_next = (r_idx == c_last) ? S_WRITEBACK : S_REQ;
                end
            end
            S_WRITEBACK: begin
                vreg_we_o    = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                done_o       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench for load_store_unit with a stalling DDR model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int D  = 16;
    localparam int AW = 16;
    localparam int DW = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic              ready_o;
    logic [1:0]        operation_i;
    logic [AW-1:0]     ddr_address_i;
    logic [1:0]        v_addr_i;
    logic              done_o;
    logic [1:0]        vreg_raddr_o;
    logic [D*DW-1:0]   vreg_rdata_i;
    logic              vreg_we_o;
    logic [1:0]        vreg_waddr_o;
    logic [D*DW-1:0]   vreg_wdata_o;
    logic              ddr_req_o;
    logic              ddr_we_o;
    logic [AW-1:0]     ddr_addr_o;
    logic [DW-1:0]     ddr_wdata_o;
    logic              ddr_gnt_i;
    logic              ddr_rvalid_i;
    logic [DW-1:0]     ddr_rdata_i;

    always #5 clk_i = ~clk_i;

    load_store_unit #(.D(D), .DdrAddressWidth(AW), .DdrDataWidth(DW)) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .ready_o       (ready_o),
        .operation_i   (operation_i),
        .ddr_address_i (ddr_address_i),
        .v_addr_i      (v_addr_i),
        .done_o        (done_o),
        .vreg_raddr_o  (vreg_raddr_o),
        .vreg_rdata_i  (vreg_rdata_i),
        .vreg_we_o     (vreg_we_o),
        .vreg_waddr_o  (vreg_waddr_o),
        .vreg_wdata_o  (vreg_wdata_o),
        .ddr_req_o     (ddr_req_o),
        .ddr_we_o      (ddr_we_o),
        .ddr_addr_o    (ddr_addr_o),
        .ddr_wdata_o   (ddr_wdata_o),
        .ddr_gnt_i     (ddr_gnt_i),
        .ddr_rvalid_i  (ddr_rvalid_i),
        .ddr_rdata_i   (ddr_rdata_i)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ddr_txn_t;

    typedef struct {
        logic [1:0]      waddr;
        logic [D*DW-1:0] data;
        int              lat;
    } wb_t;

    ddr_txn_t        ddr_q[$];
    wb_t             wb_q[$];
    logic [D*DW-1:0] regs [4];
    assign vreg_rdata_i = regs[vreg_raddr_o];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t0       = 0;
    int max_gnt_stall = 0;
    int max_rv_delay  = 1;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [D*DW-1:0] got, input logic [D*DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // DDR slave: random grant stall, read data = addr[7:0]^A5 after 1..max_rv_delay cycles.
    logic            held;
    logic [AW+DW:0]  held_sig;
    int              gnt_wait;
    logic            rd_pending;
    int              rd_wait;
    logic [DW-1:0]   rd_data;
    ddr_txn_t        txn;

    initial begin
        ddr_gnt_i = 1'b0; ddr_rvalid_i = 1'b0; ddr_rdata_i = '0;
        held = 1'b0; rd_pending = 1'b0; gnt_wait = 0; rd_wait = 0; rd_data = '0;
        forever begin
            @(negedge clk_i);
            ddr_gnt_i    = 1'b0;
            ddr_rvalid_i = 1'b0;
            if (rd_pending) begin
                if (rd_wait == 0) begin
                    ddr_rvalid_i = 1'b1;
                    ddr_rdata_i  = rd_data;
                    rd_pending   = 1'b0;
                end else rd_wait--;
            end
            if (ddr_req_o) begin
                if (!held) begin
                    held     = 1'b1;
                    held_sig = {ddr_we_o, ddr_addr_o, ddr_wdata_o};
                    gnt_wait = (max_gnt_stall > 0) ? int'($urandom_range(max_gnt_stall, 0)) : 0;
                end else begin
                    check("ddr_hold", {ddr_we_o, ddr_addr_o, ddr_wdata_o}, held_sig);
                end
                if (gnt_wait == 0) begin
                    ddr_gnt_i = 1'b1;
                    held      = 1'b0;
                    if (ddr_q.size() == 0) begin
                        check("ddr_unexpected_req", 1, 0);
                    end else begin
                        txn = ddr_q.pop_front();
                        check("ddr_we", ddr_we_o, txn.we);
                        check("ddr_addr", ddr_addr_o, txn.addr);
                        if (txn.we) check("ddr_wdata", ddr_wdata_o, txn.data);
                    end
                    if (!ddr_we_o) begin
                        rd_pending = 1'b1;
                        rd_data    = ddr_addr_o[7:0] ^ 8'hA5;
                        rd_wait    = int'($urandom_range(max_rv_delay, 1)) - 1;
                    end
                end else gnt_wait--;
            end
        end
    end

    wb_t wb;
    initial begin
        forever begin
            @(negedge clk_i);
            if (vreg_we_o === 1'b1) begin
                if (wb_q.size() == 0) begin
                    check("vreg_we_unexpected", 1, 0);
                end else begin
                    wb = wb_q.pop_front();
                    check("vreg_waddr", vreg_waddr_o, wb.waddr);
                    check("vreg_wdata", vreg_wdata_o, wb.data);
                    if (wb.lat >= 0) check("wb_cycle", cyc - t0, wb.lat);
                end
            end
        end
    end

    task automatic push_sv(input logic [AW-1:0] base, input logic [1:0] v);
        ddr_txn_t t;
        for (int i = 0; i < D; i++) begin
            t.we   = 1'b1;
            t.addr = base + AW'(i);
            t.data = regs[v][i*DW +: DW];
            ddr_q.push_back(t);
        end
    endtask

    task automatic push_ldv(input logic [AW-1:0] base, input logic [1:0] v, input int lat);
        ddr_txn_t        t;
        wb_t             w;
        logic [AW-1:0]   a;
        for (int i = 0; i < D; i++) begin
            a      = base + AW'(i);
            t.we   = 1'b0;
            t.addr = a;
            t.data = '0;
            ddr_q.push_back(t);
            w.data[i*DW +: DW] = a[7:0] ^ 8'hA5;
        end
        w.waddr = v;
        w.lat   = lat;
        wb_q.push_back(w);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [AW-1:0] base, input logic [1:0] v,
                          input int done_lat, input int busy_at);
        int n;
        @(posedge clk_i); #1;
        start_i = 1'b1; operation_i = op; ddr_address_i = base; v_addr_i = v;
        @(negedge clk_i);
        check("ready_at_start", ready_o, 1);
        t0 = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0; operation_i = 2'd0; ddr_address_i = '0; v_addr_i = 2'd0;
        n = 0;
        forever begin
            @(negedge clk_i);
            n++;
            if (n == busy_at) begin
                start_i = 1'b1; operation_i = 2'd0; ddr_address_i = 16'h5555; v_addr_i = 2'd3;
            end else if (n == busy_at + 1) begin
                start_i = 1'b0;
            end
            if (done_o || n > 600) break;
        end
        if (!done_o) begin
            check("done_timeout", 0, 1);
        end else begin
            if (done_lat >= 0) check("done_cycle", cyc - t0, done_lat);
            @(negedge clk_i);
            check("done_one_cycle", done_o, 0);
            check("ready_after_done", ready_o, 1);
        end
        check("ddr_q_drained", ddr_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", ready_o, 1);
        check("rst_done", done_o, 0);
        check("rst_ddr_req", ddr_req_o, 0);
        check("rst_ddr_we", ddr_we_o, 0);
        check("rst_vreg_we", vreg_we_o, 0);
        check("rst_ddr_addr", ddr_addr_o, 0);
        check("rst_ddr_wdata", ddr_wdata_o, 0);
        check("rst_vreg_waddr", vreg_waddr_o, 0);
        check("rst_vreg_wdata", vreg_wdata_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; operation_i = 2'd0; ddr_address_i = '0; v_addr_i = 2'd0;
        for (int i = 0; i < D; i++) begin
            regs[0][i*DW +: DW] = DW'(i * 7 + 3);
            regs[1][i*DW +: DW] = 8'h00;
            regs[2][i*DW +: DW] = DW'(i);
            regs[3][i*DW +: DW] = 8'h80 | DW'(i);
        end
        repeat (3) @(negedge clk_i);
        check_reset_outputs();
        rst_ni = 1'b1;

        push_sv(16'h0100, 2'd2);
        run_op(2'd1, 16'h0100, 2'd2, D + 1, -1);

        push_ldv(16'h0200, 2'd1, 2 * D + 1);
        run_op(2'd0, 16'h0200, 2'd1, 2 * D + 2, -1);

        max_gnt_stall = 3; max_rv_delay = 4;
        push_ldv(16'h0200, 2'd1, -1);
        run_op(2'd0, 16'h0200, 2'd1, -1, -1);
        push_sv(16'h0100, 2'd2);
        run_op(2'd1, 16'h0100, 2'd2, -1, -1);
        max_gnt_stall = 0; max_rv_delay = 1;

        push_sv(16'hFFF8, 2'd0);
        run_op(2'd1, 16'hFFF8, 2'd0, D + 1, -1);

        push_sv(16'h1000, 2'd3);
        run_op(2'd1, 16'h1000, 2'd3, D + 1, 5);

        run_op(2'd2, 16'h2000, 2'd1, 1, -1);
        run_op(2'd3, 16'h2000, 2'd1, 1, -1);

        // Abort an LDV in the request for element 8, after element 7 has landed.
        push_ldv(16'h0400, 2'd1, -1);
        @(posedge clk_i); #1;
        start_i = 1'b1; operation_i = 2'd0; ddr_address_i = 16'h0400; v_addr_i = 2'd1;
        @(negedge clk_i);
        t0 = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int k = 1; k < 17; k++) begin
            @(negedge clk_i);
            check("abort_no_done", done_o, 0);
        end
        @(negedge clk_i);
        check("pre_reset_req", ddr_req_o, 1);
        check("pre_reset_addr", ddr_addr_o, 16'h0408);
        #2 rst_ni = 1'b0;
        #1;
        check_reset_outputs();
        ddr_q.delete();
        wb_q.delete();
        held = 1'b0;
        rd_pending = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            check("in_reset_done", done_o, 0);
            check("in_reset_vreg_we", vreg_we_o, 0);
        end
        rst_ni = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            check("post_reset_done", done_o, 0);
            check("post_reset_ready", ready_o, 1);
        end

        push_ldv(16'h0300, 2'd3, 2 * D + 1);
        run_op(2'd0, 16'h0300, 2'd3, 2 * D + 2, -1);

        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
